led_seq_ctrl: RTL and testbench

//  Command-driven sequencer for the board LED bank. Accepts pattern commands (mode, step period,

---
 rtl/led_pkg.sv | 13 +
 rtl/led_pattern_gen.sv | 21 ++
 rtl/led_seq_ctrl.sv | 93 +++++++++
 tb/tb_led_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared mode/state encodings and pattern-length helper for the LED sequencer
package led_pkg;
   typedef enum logic [1:0] {
      MODE_SHIFT_L = 2'd0,
      MODE_SHIFT_R = 2'd1,
      MODE_BOUNCE  = 2'd2,
      MODE_BLINK   = 2'd3
   } mode_t;
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_PAUSE} state_t;
   function automatic int pat_len(mode_t mode, int led_width);
      return mode == MODE_BOUNCE ? 2 * led_width - 2 : mode == MODE_BLINK ? 2 : led_width;
   endfunction
endpackage

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: combinational LED pattern for a given mode and step index
module led_pattern_gen
   import led_pkg::*;
#(
   parameter int LED_WIDTH = 8,
   parameter int STEP_W    = 4
) (
   input  mode_t                mode,
   input  logic [STEP_W-1:0]    step,
   output logic [LED_WIDTH-1:0] pattern
);
   localparam logic [LED_WIDTH-1:0] LSB = LED_WIDTH'(1);
   localparam logic [LED_WIDTH-1:0] MSB = LSB << (LED_WIDTH - 1);
   logic [STEP_W-1:0] back;
   // return leg of the bounce starts one above the LSB so the ends are not repeated
   assign back = step - STEP_W'(LED_WIDTH - 1);
   assign pattern = mode == MODE_SHIFT_L ? LSB << step
                  : mode == MODE_SHIFT_R ? MSB >> step
                  : mode == MODE_BOUNCE  ? (step < STEP_W'(LED_WIDTH) ? MSB >> step : LSB << back)
                  : {LED_WIDTH{~step[0]}};
endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: command-driven LED pattern sequencer with a one-deep pending command slot
module led_seq_ctrl
   import led_pkg::*;
#(
   parameter int LED_WIDTH = 8,
   parameter int PERIOD_W  = 24,
   parameter int CYCLE_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [1:0]           cmd_mode,
   input  logic [PERIOD_W-1:0]  cmd_period,
   input  logic [CYCLE_W-1:0]   cmd_cycles,
   input  logic                 pause,
   input  logic                 abort,
   output logic [LED_WIDTH-1:0] led_data,
   output logic                 busy,
   output logic                 done
);
   localparam int STEP_W = $clog2(2 * LED_WIDTH);
   state_t state;
   logic pend_full;
   mode_t pend_mode, mode, gen_mode;
   logic [PERIOD_W-1:0] pend_period, period, prescale;
   logic [CYCLE_W-1:0] pend_cycles, cycles, cyc_cnt;
   logic [STEP_W-1:0] step, step_nxt, last_step, gen_step;
   logic [LED_WIDTH-1:0] pat;
   logic accept, active, step_end, boundary, finish, preempt;
   assign cmd_ready = !pend_full && !abort;
   assign accept = cmd_valid && cmd_ready;
   assign busy = state != ST_IDLE;
   assign last_step = STEP_W'(pat_len(mode, LED_WIDTH) - 1);
   // a cleared pause counts the resume clock as a run clock, so a pause costs exactly its length
   assign active = (state == ST_RUN || state == ST_PAUSE) && !pause && !abort && !rst;
   assign step_end = active && prescale == period;
   assign boundary = step_end && step == last_step;
   assign finish = boundary && cycles != '0 && cyc_cnt == cycles - 1'b1;
   assign preempt = boundary && cycles == '0 && pend_full;
   assign done = finish;
   assign step_nxt = boundary ? '0 : step + 1'b1;
   assign gen_mode = state == ST_LOAD ? pend_mode : mode;
   assign gen_step = state == ST_LOAD ? '0 : step_nxt;
   led_pattern_gen #(
      .LED_WIDTH(LED_WIDTH),
      .STEP_W   (STEP_W)
   ) u_gen (
      .mode   (gen_mode),
      .step   (gen_step),
      .pattern(pat)
   );
   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state <= ST_IDLE;
         pend_full <= 1'b0;
         led_data <= '0;
      end else begin
         pend_full <= (pend_full && state != ST_LOAD) || accept;
         case (state)
            ST_IDLE: state <= pend_full ? ST_LOAD : ST_IDLE;
            ST_LOAD: begin
               state <= ST_RUN;
               mode <= pend_mode;
               period <= pend_period;
               cycles <= pend_cycles;
               prescale <= '0;
               step <= '0;
               cyc_cnt <= '0;
               led_data <= pat;
            end
            default: begin
               state <= pause ? ST_PAUSE : ST_RUN;
               if (!pause) begin
                  prescale <= step_end ? '0 : prescale + 1'b1;
                  if (step_end) step <= step_nxt;
                  if (step_end && !preempt) led_data <= pat;
                  if (finish) begin
                     led_data <= '0;
                     state <= pend_full ? ST_LOAD : ST_IDLE;
                  end else if (preempt) state <= ST_LOAD;
                  else if (boundary) cyc_cnt <= cyc_cnt + 1'b1;
               end
            end
         endcase
      end
      if (accept) begin
         pend_mode <= mode_t'(cmd_mode);
         pend_period <= cmd_period;
         pend_cycles <= cmd_cycles;
      end
   end
endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: scoreboard bench for led_seq_ctrl at LED_WIDTH=8
module tb_led_seq_ctrl;
   typedef struct packed {
      logic [7:0] led;
      logic done;
      logic busy;
      logic ready;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_valid = 1'b0, cmd_ready;
   logic [1:0] cmd_mode = '0;
   logic [23:0] cmd_period = '0;
   logic [7:0] cmd_cycles = '0;
   logic pause = 1'b0, abort = 1'b0;
   logic [7:0] led_data;
   logic busy, done;
   int passed = 0, checks = 0;
   exp_t exp_q[$];
   led_seq_ctrl #(.LED_WIDTH(8), .PERIOD_W(24), .CYCLE_W(8)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_mode(cmd_mode), .cmd_period(cmd_period), .cmd_cycles(cmd_cycles),
      .pause(pause), .abort(abort), .led_data(led_data), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   function automatic int plen(int m);
      return m == 2 ? 14 : m == 3 ? 2 : 8;
   endfunction
   function automatic logic [7:0] exp_pat(int m, int s);
      logic [7:0] bt [14];
      bt = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
             8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};
      case (m)
         0: return 8'h01 << s;
         1: return 8'h80 >> s;
         2: return bt[s];
         default: return s == 0 ? 8'hFF : 8'h00;
      endcase
   endfunction
   function automatic string show(exp_t v);
      return $sformatf("led=%h done=%b busy=%b ready=%b", v.led, v.done, v.busy, v.ready);
   endfunction
   task automatic push(input logic [7:0] led, input logic d, input logic b, input logic r);
      exp_q.push_back(exp_t'{led, d, b, r});
   endtask
   task automatic push_run(input int m, input int p, input int c);
      for (int ci = 0; ci < c; ci++)
         for (int s = 0; s < plen(m); s++)
            for (int q = 0; q <= p; q++)
               push(exp_pat(m, s), ci == c - 1 && s == plen(m) - 1 && q == p, 1'b1, 1'b1);
   endtask
   task automatic send(input logic [1:0] m, input int p, input int c);
      cmd_mode = m;
      cmd_period = 24'(p);
      cmd_cycles = 8'(c);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask
   task automatic test_reset();
      exp_t e, got;
      int n;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (100) push(8'h00, 1'b0, 1'b0, 1'b1);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         got = {led_data, done, busy, cmd_ready};
         checks++;
         if (got !== e) $display("FAIL reset k=%0d got %s want %s", k, show(got), show(e));
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_shift_l();
      exp_t e, got;
      int n;
      send(2'd0, 3, 1);
      push(8'h00, 1'b0, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b1, 1'b0);
      push_run(0, 3, 1);
      repeat (3) push(8'h00, 1'b0, 1'b0, 1'b1);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         got = {led_data, done, busy, cmd_ready};
         checks++;
         if (got !== e) $display("FAIL shift_l k=%0d got %s want %s", k, show(got), show(e));
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_bounce();
      exp_t e, got;
      int n;
      send(2'd2, 0, 2);
      push(8'h00, 1'b0, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b1, 1'b0);
      push_run(2, 0, 2);
      repeat (3) push(8'h00, 1'b0, 1'b0, 1'b1);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         got = {led_data, done, busy, cmd_ready};
         checks++;
         if (got !== e) $display("FAIL bounce k=%0d got %s want %s", k, show(got), show(e));
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_preempt();
      exp_t e, got;
      int n;
      send(2'd3, 1, 0);
      push(8'h00, 1'b0, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b1, 1'b0);
      push(8'hFF, 1'b0, 1'b1, 1'b1);
      push(8'hFF, 1'b0, 1'b1, 1'b0);
      repeat (3) push(8'h00, 1'b0, 1'b1, 1'b0);
      push_run(1, 0, 1);
      repeat (2) push(8'h00, 1'b0, 1'b0, 1'b1);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         if (k == 2) begin
            cmd_mode = 2'd1;
            cmd_period = '0;
            cmd_cycles = 8'd1;
            cmd_valid = 1'b1;
         end
         if (k == 3) cmd_valid = 1'b0;
         @(negedge clk);
         e = exp_q.pop_front();
         got = {led_data, done, busy, cmd_ready};
         checks++;
         if (got !== e) $display("FAIL preempt k=%0d got %s want %s", k, show(got), show(e));
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_pause();
      exp_t e, got;
      int n;
      send(2'd0, 1, 1);
      push(8'h00, 1'b0, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b1, 1'b0);
      for (int s = 0; s < 8; s++)
         for (int q = 0; q < 2; q++) begin
            push(exp_pat(0, s), s == 7 && q == 1, 1'b1, 1'b1);
            if (s == 3 && q == 0) repeat (10) push(8'h08, 1'b0, 1'b1, 1'b1);
         end
      repeat (2) push(8'h00, 1'b0, 1'b0, 1'b1);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         if (k == 8) pause = 1'b1;
         if (k == 18) pause = 1'b0;
         @(negedge clk);
         e = exp_q.pop_front();
         got = {led_data, done, busy, cmd_ready};
         checks++;
         if (got !== e) $display("FAIL pause k=%0d got %s want %s", k, show(got), show(e));
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_back_to_back();
      exp_t e, got;
      int n;
      send(2'd3, 0, 1);
      push(8'h00, 1'b0, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b1, 1'b0);
      push(8'hFF, 1'b0, 1'b1, 1'b1);
      push(8'h00, 1'b1, 1'b1, 1'b0);
      push(8'h00, 1'b0, 1'b1, 1'b0);
      push_run(0, 0, 1);
      repeat (2) push(8'h00, 1'b0, 1'b0, 1'b1);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         if (k == 2) begin
            cmd_mode = 2'd0;
            cmd_period = '0;
            cmd_cycles = 8'd1;
            cmd_valid = 1'b1;
         end
         if (k == 3) cmd_valid = 1'b0;
         @(negedge clk);
         e = exp_q.pop_front();
         got = {led_data, done, busy, cmd_ready};
         checks++;
         if (got !== e) $display("FAIL back_to_back k=%0d got %s want %s", k, show(got), show(e));
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   task automatic test_abort();
      exp_t e, got;
      int n;
      send(2'd0, 3, 0);
      push(8'h00, 1'b0, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b1, 1'b0);
      repeat (2) push(8'h01, 1'b0, 1'b1, 1'b1);
      repeat (2) push(8'h01, 1'b0, 1'b1, 1'b0);
      push(8'h02, 1'b0, 1'b1, 1'b0);
      push(8'h00, 1'b0, 1'b0, 1'b0);
      repeat (5) push(8'h00, 1'b0, 1'b0, 1'b1);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         if (k == 3) begin
            cmd_mode = 2'd1;
            cmd_period = '0;
            cmd_cycles = 8'd1;
            cmd_valid = 1'b1;
         end
         if (k == 4) cmd_valid = 1'b0;
         if (k == 6) {abort, cmd_valid} = 2'b11;
         if (k == 8) {abort, cmd_valid} = 2'b00;
         @(negedge clk);
         e = exp_q.pop_front();
         got = {led_data, done, busy, cmd_ready};
         checks++;
         if (got !== e) $display("FAIL abort k=%0d got %s want %s", k, show(got), show(e));
         else passed++;
         @(posedge clk); #1;
      end
      send(2'd1, 0, 1);
      push(8'h00, 1'b0, 1'b0, 1'b0);
      push(8'h00, 1'b0, 1'b1, 1'b0);
      push_run(1, 0, 1);
      repeat (2) push(8'h00, 1'b0, 1'b0, 1'b1);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         e = exp_q.pop_front();
         got = {led_data, done, busy, cmd_ready};
         checks++;
         if (got !== e) $display("FAIL after_abort k=%0d got %s want %s", k, show(got), show(e));
         else passed++;
         @(posedge clk); #1;
      end
   endtask
   initial begin
      test_reset();
      test_shift_l();
      test_bounce();
      test_preempt();
      test_pause();
      test_back_to_back();
      test_abort();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish within time budget");
      $fatal(1);
   end
endmodule
